flow_mem_resp: RTL and testbench

- Memory responder: the target end of the mem_ce/mem_we/mem_addr/mem_width/mem_data/mem_ready interface that the packet processor's matcher drives.
- Holds match-action table contents in a byte-addressed array and answers one request at a time after a fixed, parameterised latency.
- A control-plane write port loads table entries between packet accesses.

---
 rtl/flow_mem_resp_pkg.sv | 29 ++
 rtl/flow_mem_resp_if.sv | 30 +++
 rtl/flow_mem_resp_byte_ram.sv | 34 +++
 rtl/flow_mem_resp.sv | 121 ++++++++++++
 tb/tb_flow_mem_resp.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/flow_mem_resp_pkg.sv
// Shared definitions for the flow table memory responder.
// Bus widths, defaults, access-width helpers and the responder state enum.
package flow_mem_resp_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int MEM_DEPTH   = 4096;
    localparam int MEM_LATENCY = 2;
    localparam int MAX_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic [2:0] clip_width(input logic [3:0] w);
        return (w > 4'(MAX_WIDTH)) ? 3'(MAX_WIDTH) : w[2:0];
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] w);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (3'(i) < w);
        end
        return m;
    endfunction

endpackage

// File: rtl/flow_mem_resp_if.sv
// Matcher-side memory bus plus control-plane write port.
// The responder uses the slave modport, the matcher/control plane the master.
interface flow_mem_resp_if;
    import flow_mem_resp_pkg::*;

    logic              mem_ce_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [3:0]        mem_width_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ready_o;
    logic              cfg_we_i;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic [DATA_W-1:0] cfg_data_i;
    logic              cfg_ack_o;

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
        input  cfg_we_i, cfg_addr_i, cfg_data_i,
        output mem_data_o, mem_ready_o, cfg_ack_o
    );

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
        output cfg_we_i, cfg_addr_i, cfg_data_i,
        input  mem_data_o, mem_ready_o, cfg_ack_o
    );

endinterface

// File: rtl/flow_mem_resp_byte_ram.sv
// Byte-addressed table storage: four byte write lanes and a 4-byte
// combinational read, each lane wrapping independently at DEPTH.
module flow_mem_resp_byte_ram
    import flow_mem_resp_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [AW-1:0]     waddr,
    input  logic [3:0]        wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                mem[waddr + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[8*i +: 8] = mem[raddr + AW'(i)];
        end
    end

endmodule

// File: rtl/flow_mem_resp.sv
// Memory responder for the packet matcher: one access at a time,
// fixed response latency, control-plane writes taken only while idle.
module flow_mem_resp
    import flow_mem_resp_pkg::*;
#(
    parameter int DEPTH   = MEM_DEPTH,
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic clk,
    input  logic rst,
    flow_mem_resp_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              rdv_q, rdv_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ack_q, ack_d;

    logic [AW-1:0]     waddr;
    logic [3:0]        wen;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] rd_now;
    logic [3:0]        mask;
    logic              unused_hi;

    assign unused_hi = ^{bus.mem_addr_i[ADDR_W-1:AW],
                         bus.cfg_addr_i[ADDR_W-1:AW]};

    flow_mem_resp_byte_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .waddr (waddr),
        .wen   (wen),
        .wdata (wdata),
        .raddr (bus.mem_addr_i[AW-1:0]),
        .rdata (rdata)
    );

    assign mask = lane_mask(clip_width(bus.mem_width_i));

    // Unused upper lanes read as zero; width 0 yields all-zero data.
    always_comb begin
        rd_now = '0;
        for (int i = 0; i < 4; i++) begin
            rd_now[8*i +: 8] = mask[i] ? rdata[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        rdv_d   = rdv_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        waddr   = bus.mem_addr_i[AW-1:0];
        wdata   = bus.mem_data_i;
        wen     = 4'h0;
        unique case (state_q)
            IDLE: begin
                if (bus.cfg_we_i) begin
                    waddr = bus.cfg_addr_i[AW-1:0];
                    wdata = bus.cfg_data_i;
                    wen   = 4'hF;
                    ack_d = 1'b1;
                end else if (bus.mem_ce_i) begin
                    wen   = bus.mem_we_i ? mask : 4'h0;
                    rd_d  = rd_now;
                    rdv_d = ~bus.mem_we_i;
                    cnt_d = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        if (!bus.mem_we_i) data_d = rd_now;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    if (rdv_q) data_d = rd_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            rdv_q   <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            rdv_q   <= rdv_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.mem_ready_o = (state_q == RESP);
    assign bus.mem_data_o  = data_q;
    assign bus.cfg_ack_o   = ack_q;

endmodule

// File: tb/tb_flow_mem_resp.sv
// Randomised bench for flow_mem_resp against a cycle-timed byte-array model.
// Directed scenarios first, then random cfg/mem traffic.
module tb_flow_mem_resp;
    import flow_mem_resp_pkg::*;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    flow_mem_resp_if bus();

    flow_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Reference: byte array plus the cycle numbers at which pulses are due.
    logic [7:0]  mm [DEPTH];
    int          free_at  = 0;
    int          exp_rdy  = -1;
    int          exp_ack  = -1;
    logic        pend_rd  = 1'b0;
    logic [31:0] pend_val = '0;
    logic [31:0] exp_data = '0;

    function automatic logic [31:0] model_read(input logic [31:0] a,
                                               input int w);
        logic [31:0] r;
        int n;
        r = '0;
        n = (w > 4) ? 4 : w;
        for (int i = 0; i < n; i++) begin
            r[8*i +: 8] = mm[(int'(a % DEPTH) + i) % DEPTH];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            free_at  = 0;
            exp_rdy  = -1;
            exp_ack  = -1;
            pend_rd  = 1'b0;
            exp_data = '0;
        end
        if (cyc == exp_rdy && pend_rd) exp_data = pend_val;
        check("mem_ready_o", {31'b0, bus.mem_ready_o}, {31'b0, cyc == exp_rdy});
        check("cfg_ack_o", {31'b0, bus.cfg_ack_o}, {31'b0, cyc == exp_ack});
        check("mem_data_o", bus.mem_data_o, exp_data);
        if (!rst && cyc >= free_at) begin
            if (bus.cfg_we_i) begin
                for (int i = 0; i < 4; i++)
                    mm[(int'(bus.cfg_addr_i % DEPTH) + i) % DEPTH] =
                        bus.cfg_data_i[8*i +: 8];
                exp_ack = cyc + 1;
                free_at = cyc + 1;
            end else if (bus.mem_ce_i) begin
                int w;
                w = (bus.mem_width_i > 4) ? 4 : int'(bus.mem_width_i);
                if (bus.mem_we_i) begin
                    for (int i = 0; i < w; i++)
                        mm[(int'(bus.mem_addr_i % DEPTH) + i) % DEPTH] =
                            bus.mem_data_i[8*i +: 8];
                    pend_rd = 1'b0;
                end else begin
                    pend_rd  = 1'b1;
                    pend_val = model_read(bus.mem_addr_i, w);
                end
                exp_rdy = cyc + LAT;
                free_at = cyc + LAT + 1;
            end
        end
    end

    // Drivers start at #1 after a rising edge and return at #1 after the
    // edge where the completion pulse appears.
    task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d,
                          output int lat);
        bus.cfg_we_i   = 1'b1;
        bus.cfg_addr_i = a;
        bus.cfg_data_i = d;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.cfg_ack_o && lat < 64);
        check("cfg_handshake", {31'b0, bus.cfg_ack_o}, 32'd1);
        bus.cfg_we_i = 1'b0;
    endtask

    task automatic mem_op(input logic we, input logic [31:0] a,
                          input logic [3:0] w, input logic [31:0] d,
                          output int lat);
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_addr_i  = a;
        bus.mem_width_i = w;
        bus.mem_data_i  = d;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.mem_ready_o && lat < 64);
        check("mem_handshake", {31'b0, bus.mem_ready_o}, 32'd1);
        bus.mem_ce_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int l1, l2;
        logic [31:0] a;
        bus.mem_ce_i    = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = '0;
        bus.mem_width_i = '0;
        bus.mem_data_i  = '0;
        bus.cfg_we_i    = 1'b0;
        bus.cfg_addr_i  = '0;
        bus.cfg_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, bus.mem_ready_o}, 32'd0);
        check("reset_ack", {31'b0, bus.cfg_ack_o}, 32'd0);
        check("reset_data", bus.mem_data_o, 32'd0);
        rst = 1'b0;

        cfg_wr(32'h10, 32'hDDCCBBAA, l1);
        check("cfg_ack_latency", l1, 1);
        mem_op(1'b0, 32'h10, 4'd4, '0, l1);
        check("read_latency", l1, 2);
        check("read_w4", bus.mem_data_o, 32'hDDCCBBAA);
        check("model_pin", model_read(32'h10, 4), 32'hDDCCBBAA);
        mem_op(1'b0, 32'h11, 4'd2, '0, l1);
        check("read_w2", bus.mem_data_o, 32'h0000CCBB);
        mem_op(1'b0, 32'h10, 4'd0, '0, l1);
        check("read_w0", bus.mem_data_o, 32'h0);
        mem_op(1'b0, 32'h10, 4'd9, '0, l1);
        check("read_w9", bus.mem_data_o, 32'hDDCCBBAA);

        mem_op(1'b1, 32'hFFE, 4'd4, 32'h44332211, l1);
        mem_op(1'b0, 32'hFFE, 4'd2, '0, l1);
        check("read_top", bus.mem_data_o, 32'h00002211);
        mem_op(1'b0, 32'h0, 4'd2, '0, l1);
        check("read_wrap", bus.mem_data_o, 32'h00004433);
        mem_op(1'b0, 32'h1234_5010, 4'd4, '0, l1);
        check("read_hi_addr", bus.mem_data_o, 32'hDDCCBBAA);

        @(posedge clk);
        #1;
        fork
            cfg_wr(32'h20, 32'h87654321, l1);
            mem_op(1'b0, 32'h20, 4'd4, '0, l2);
        join
        check("prio_cfg_lat", l1, 1);
        check("prio_mem_lat", l2, 3);
        check("prio_data", bus.mem_data_o, 32'h87654321);

        for (int k = 0; k < 4; k++) begin
            mem_op(1'b0, 32'h10 + 32'(k), 4'd4, '0, l1);
            check("b2b_spacing", l1, LAT + 1);
        end

        fork
            mem_op(1'b0, 32'h20, 4'd4, '0, l1);
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                cfg_wr(32'h24, 32'hCAFEF00D, l2);
            end
        join
        check("wait_cfg_lat", l2, 3);
        mem_op(1'b0, 32'h24, 4'd4, '0, l1);
        check("wait_cfg_data", bus.mem_data_o, 32'hCAFEF00D);

        @(posedge clk);
        #1;
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = 32'h24;
        bus.mem_width_i = 4'd4;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mem_ce_i = 1'b0;
        #1;
        check("rst_wait_ready", {31'b0, bus.mem_ready_o}, 32'd0);
        check("rst_wait_data", bus.mem_data_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_op(1'b0, 32'h10, 4'd4, '0, l1);
        check("post_rst_lat", l1, 2);
        check("post_rst_data", bus.mem_data_o, 32'hDDCCBBAA);

        for (int i = 0; i < 16; i++) cfg_wr(32'(4 * i), $urandom, l1);
        cfg_wr(32'hFF8, $urandom, l1);
        cfg_wr(32'hFFC, $urandom, l1);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 56))
                                            : 32'(DEPTH - 8 + $urandom_range(0, 7));
            a = a | ($urandom & ~32'(DEPTH - 1));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 5))
                0: cfg_wr(a, $urandom, l1);
                1: fork
                    cfg_wr(a, $urandom, l1);
                    mem_op(1'b0, a, 4'($urandom_range(0, 9)), '0, l2);
                join
                2, 3: mem_op(1'b1, a, 4'($urandom_range(0, 9)), $urandom, l1);
                default: mem_op(1'b0, a, 4'($urandom_range(0, 9)), '0, l1);
            endcase
        end

        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
